// File: rtl/arm_pipe_pkg.sv
// Shared pipeline types for the hazard unit.
//   fwd_t       : Execute operand source select (register file, Writeback, Memory).
//   mem_state_t : data-memory wait tracker states.
package arm_pipe_pkg;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_t;

  typedef enum logic {
    MIDLE = 1'b0,
    MWAIT = 1'b1
  } mem_state_t;

  localparam logic [7:0] WAIT_MAX = 8'hFF;

endpackage

// File: rtl/hazard_unit_fwdsel.sv
// fwdsel: forward select for one Execute operand.
// Ports:
//   validE             : Execute-stage source address is live
//   raE                : Execute-stage source register
//   wa3M, regWriteM    : Memory-stage destination and its write enable
//   wa3W, regWriteW    : Writeback-stage destination and its write enable
//   fwd                : selected operand source
// The Memory stage holds the younger result, so it wins over Writeback.
module fwdsel
  import arm_pipe_pkg::*;
(
  input  logic       validE,
  input  logic [3:0] raE,
  input  logic [3:0] wa3M,
  input  logic       regWriteM,
  input  logic [3:0] wa3W,
  input  logic       regWriteW,
  output fwd_t       fwd
);

  always_comb begin
    fwd = FWD_RF;
    if (validE && (raE == wa3M) && regWriteM) begin
      fwd = FWD_M;
    end else if ((raE == wa3W) && regWriteW) begin
      fwd = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding, load-use stall, branch flush and data-memory
// freeze control for a five-stage pipeline.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   RA1D, RA2D                 : Decode source registers
//   WA3E, WA3M, WA3W           : destinations in Execute/Memory/Writeback
//   RegWriteM, RegWriteW       : register-write enables in Memory/Writeback
//   MemtoRegE                  : Execute instruction is a load
//   PCSrcD/E/M/W, BranchTakenE : PC-write indications per stage
//   MemReqM, MemReady          : Memory-stage access and its completion
//   ForwardAE, ForwardBE       : Execute operand source selects
//   StallF/D/E/M, FlushD/E/W   : pipeline register enables and clears
//   WaitCycles                 : saturating count of memory-stall cycles
module hazard_unit
  import arm_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3E,
  input  logic [3:0] WA3M,
  input  logic [3:0] WA3W,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCSrcD,
  input  logic       PCSrcE,
  input  logic       PCSrcM,
  input  logic       PCSrcW,
  input  logic       BranchTakenE,
  input  logic       MemReqM,
  input  logic       MemReady,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       StallM,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushW,
  output logic [7:0] WaitCycles
);

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == WAIT_MAX) ? WAIT_MAX : v + 8'd1;
  endfunction

  mem_state_t memState;
  logic [3:0] RA1E, RA2E;
  logic       validE;
  logic       ldrstall, pcWrPending, memstall;
  fwd_t       fwdA, fwdB;

  assign ldrstall    = MemtoRegE & ((RA1D == WA3E) | (RA2D == WA3E));
  assign pcWrPending = PCSrcD | PCSrcE | PCSrcM;
  // A miss stalls in the very cycle it is seen, before the FSM has moved.
  assign memstall    = ((memState == MIDLE) & MemReqM & ~MemReady) |
                       ((memState == MWAIT) & ~MemReady);

  // Decode -> Execute source-address capture
  always_ff @(posedge clk) begin
    if (reset) begin
      RA1E   <= 4'd0;
      RA2E   <= 4'd0;
      validE <= 1'b0;
    end else if (!StallE) begin
      RA1E   <= RA1D;
      RA2E   <= RA2D;
      validE <= ~FlushE;
    end
  end

  // Memory wait tracking and stall-cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      memState   <= MIDLE;
      WaitCycles <= 8'd0;
    end else begin
      case (memState)
        MIDLE:   if (MemReqM && !MemReady) memState <= MWAIT;
        MWAIT:   if (MemReady)             memState <= MIDLE;
        default:                           memState <= MIDLE;
      endcase
      if (memstall) WaitCycles <= satInc(WaitCycles);
    end
  end

  fwdsel uFwdA (
    .validE   (validE),
    .raE      (RA1E),
    .wa3M     (WA3M),
    .regWriteM(RegWriteM),
    .wa3W     (WA3W),
    .regWriteW(RegWriteW),
    .fwd      (fwdA)
  );

  fwdsel uFwdB (
    .validE   (validE),
    .raE      (RA2E),
    .wa3M     (WA3M),
    .regWriteM(RegWriteM),
    .wa3W     (WA3W),
    .regWriteW(RegWriteW),
    .fwd      (fwdB)
  );

  // A memory freeze holds every stage, so branch and load-use clears
  // must wait until the pipeline moves again.
  always_comb begin
    ForwardAE = fwdA;
    ForwardBE = fwdB;
    StallF    = memstall | ldrstall | pcWrPending;
    StallD    = memstall | ldrstall;
    StallE    = memstall;
    StallM    = memstall;
    FlushW    = memstall;
    FlushD    = ~memstall & (pcWrPending | PCSrcW | BranchTakenE);
    FlushE    = ~memstall & (ldrstall | BranchTakenE);
    if (reset) begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushW    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
    end
  end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 The block SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 The block SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 The block SHALL have ports: RA1D, RA2D  input  4 each  Decode-stage register source addresses.
REQ-004 The block SHALL have ports: WA3E, WA3M, WA3W  input  4 each  destination register of the Execute, Memory and Writeback instructions.
REQ-005 The block SHALL have ports: RegWriteM, RegWriteW, MemtoRegE  input  1 each  pipelined control from the controller.
REQ-006 The block SHALL have ports: PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE  input  1 each  PC-write indications per stage.
REQ-007 The block SHALL have ports: MemReqM  input  1  load/store in Memory stage; MemReady  input  1  data memory completes this cycle.
REQ-008 The block SHALL have ports: ForwardAE, ForwardBE  output  2 each  Execute operand source select.
REQ-009 The block SHALL have ports: StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW  output  1 each  pipeline register enables and clears.
REQ-010 The block SHALL have port: WaitCycles  output  8  saturating count of memory-stall cycles.

Function
REQ-011 The block SHALL register RA1D/RA2D into RA1E/RA2E plus a valid bit on each clk when StallE=0; FlushE=1 SHALL clear the valid bit.
REQ-012 ForwardAE SHALL be 2'b10 when validE and RA1E==WA3M and RegWriteM=1, else 2'b01 when RA1E==WA3W and RegWriteW=1, else 2'b00 (Memory priority over Writeback); ForwardBE SHALL follow the same rule using RA2E.
REQ-013 ldrstall SHALL be MemtoRegE & ((RA1D==WA3E) | (RA2D==WA3E)); it SHALL assert StallF, StallD and FlushE for exactly one cycle per load-use pair.
REQ-014 PCWrPending SHALL be PCSrcD|PCSrcE|PCSrcM; StallF SHALL also assert while PCWrPending=1.
REQ-015 FlushD SHALL assert when PCWrPending|PCSrcW|BranchTakenE; FlushE SHALL also assert when BranchTakenE.
REQ-016 A memory-wait FSM SHALL have states MIDLE and MWAIT: MIDLE->MWAIT when MemReqM=1 and MemReady=0; MWAIT->MIDLE when MemReady=1; otherwise hold.
REQ-017 memstall SHALL be (MIDLE & MemReqM & !MemReady) | (MWAIT & !MemReady), combinational, same cycle.
REQ-018 While memstall=1: StallF, StallD, StallE and StallM SHALL be 1, FlushW SHALL be 1, and FlushD/FlushE SHALL be 0 (freeze dominates branch and load-use actions).
REQ-019 When memstall=0, StallE, StallM and FlushW SHALL be 0.
REQ-020 WaitCycles SHALL increment by 1 on each clk with memstall=1 and saturate at 8'hFF.
REQ-021 Load-use and branch-taken in the same cycle SHALL give FlushE=1, FlushD=1, StallD=1, StallF=1.

Reset
REQ-022 While reset=1, on clk: FSM->MIDLE, valid bits->0, RA1E/RA2E->0, WaitCycles->0.
REQ-023 While reset=1, ForwardAE=ForwardBE=2'b00, all Stall outputs 0, FlushD=FlushE=1, FlushW=0, regardless of other inputs.
REQ-024 Reset asserted in MWAIT SHALL return the FSM to MIDLE on the next clk, with no stall held after reset deasserts unless a new miss occurs.

Structure
REQ-025 A shared package arm_pipe_pkg SHALL hold fwd_t (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10) and mem_state_t (MIDLE, MWAIT).
REQ-026 One sub-module fwdsel SHALL compute one forward select; it SHALL be instantiated twice (operands A and B).

Verification
REQ-027 RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=2'b10; then drop RegWriteM -> ForwardAE=2'b01.
REQ-028 LDR R2 in E (MemtoRegE=1, WA3E=2) with RA2D=2 -> StallF=StallD=FlushE=1 for one cycle; next cycle ForwardBE=2'b01 once the load reaches W.
REQ-029 BranchTakenE=1 -> FlushD=FlushE=1 in that cycle; PCSrcD=1 -> StallF=1 and FlushD=1 until PCSrcW clears.
REQ-030 MemReqM=1, MemReady=0 for 3 cycles then 1 -> Stall{F,D,E,M}=1 and FlushW=1 for 3 cycles, FSM back to MIDLE, WaitCycles=3.
REQ-031 Hold memory miss 300 cycles -> WaitCycles=8'hFF, no wrap; assert reset mid-wait -> MIDLE, WaitCycles=0, FlushD=FlushE=1 during reset.
